// File: rtl/aemb2_intc.sv
// AEMB2 interrupt controller: synchronised sources, edge/level pending register,
// enable mask, lowest-index vector and a registered level request on a wishbone slave.

module aemb2_intc_src (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    input  logic edge_q_i,   // current type, 1 = edge
    input  logic edge_d_i,   // type after this cycle's ITR write
    input  logic clr_i,      // write-1-clear from ISR access
    output logic pend_o
);
    logic s1_q, s2_q, s3_q;
    logic pend_q, pend_d;
    logic rise_w;

    assign rise_w = s2_q & ~s3_q;

    // A source switching to edge drops its stale level state before the set term.
    always_comb begin
        pend_d = s2_q;
        if (edge_d_i & ~edge_q_i)
            pend_d = rise_w;
        else if (edge_q_i)
            pend_d = (pend_q & ~clr_i) | rise_w;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            s1_q   <= irq_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
endmodule

module aemb2_intc #(
    parameter int IRQ = 8
) (
    input  logic           sys_clk_i,
    input  logic           sys_rst_i,
    input  logic [IRQ-1:0] irq_i,
    output logic           sys_int_o,
    input  logic           wb_stb_i,
    input  logic           wb_wre_i,
    input  logic [1:0]     wb_adr_i,
    input  logic [31:0]    wb_dat_i,
    output logic [31:0]    wb_dat_o,
    output logic           wb_ack_o
);
    localparam logic [1:0] ADR_ISR = 2'd0;
    localparam logic [1:0] ADR_IER = 2'd1;
    localparam logic [1:0] ADR_IVR = 2'd2;
    localparam logic [1:0] ADR_ITR = 2'd3;

    logic [IRQ-1:0] isr_w, ier_q, ier_d, itr_q, itr_d, clr_w, hit_w;
    logic           int_q, ack_q;
    logic [31:0]    dat_q, dat_d, ivr_w;
    logic           wr_w, rd_w;
    logic [4:0]     idx_w;
    logic           unused_dat_w;

    // Upper data bits only matter when IRQ < 32; keep them formally consumed.
    assign unused_dat_w = ^wb_dat_i;

    // The ~ack term limits each held strobe to a single commit/capture.
    assign wr_w = wb_stb_i &  wb_wre_i & ~ack_q;
    assign rd_w = wb_stb_i & ~wb_wre_i & ~ack_q;

    always_comb begin
        clr_w = '0;
        ier_d = ier_q;
        itr_d = itr_q;
        if (wr_w) begin
            case (wb_adr_i)
                ADR_ISR: clr_w = wb_dat_i[IRQ-1:0];
                ADR_IER: ier_d = wb_dat_i[IRQ-1:0];
                ADR_ITR: itr_d = wb_dat_i[IRQ-1:0];
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < IRQ; g++) begin : g_src
        aemb2_intc_src u_src (
            .clk_i    (sys_clk_i),
            .rst_i    (sys_rst_i),
            .irq_i    (irq_i[g]),
            .edge_q_i (itr_q[g]),
            .edge_d_i (itr_d[g]),
            .clr_i    (clr_w[g]),
            .pend_o   (isr_w[g])
        );
    end

    assign hit_w = isr_w & ier_q;

    always_comb begin
        idx_w = '0;
        for (int i = IRQ - 1; i >= 0; i--)
            if (hit_w[i]) idx_w = 5'(i);
    end

    assign ivr_w = {~|hit_w, 26'd0, idx_w};

    always_comb begin
        dat_d = dat_q;
        if (rd_w) begin
            case (wb_adr_i)
                ADR_ISR: dat_d = 32'(isr_w);
                ADR_IER: dat_d = 32'(ier_q);
                ADR_IVR: dat_d = ivr_w;
                ADR_ITR: dat_d = 32'(itr_q);
                default: dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ier_q <= '0;
            itr_q <= '0;
            int_q <= 1'b0;
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ier_q <= ier_d;
            itr_q <= itr_d;
            int_q <= |hit_w;
            ack_q <= wb_stb_i;
            dat_q <= dat_d;
        end
    end

    assign sys_int_o = int_q;
    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
endmodule

// File: tb/tb_aemb2_intc.sv
// Directed bench for aemb2_intc: bus handshake, edge/level pending, vector, reset.

module tb_aemb2_intc;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        sint;
    logic        stb, wre;
    logic [1:0]  adr;
    logic [31:0] wdat, rdat;
    logic        ack;

    int errs = 0;
    int checks = 0;
    logic [31:0] d;
    logic        int_at_commit;

    aemb2_intc #(.IRQ(8)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .irq_i     (irq),
        .sys_int_o (sint),
        .wb_stb_i  (stb),
        .wb_wre_i  (wre),
        .wb_adr_i  (adr),
        .wb_dat_i  (wdat),
        .wb_dat_o  (rdat),
        .wb_ack_o  (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] v);
        stb = 1'b1; wre = 1'b1; adr = a; wdat = v;
        @(negedge clk);
        int_at_commit = sint;
        stb = 1'b0; wre = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] v);
        stb = 1'b1; wre = 1'b0; adr = a;
        @(negedge clk);
        chk("ack_rise", {31'd0, ack}, 32'd1);
        v = rdat;
        stb = 1'b0;
        @(negedge clk);
        chk("ack_fall", {31'd0, ack}, 32'd0);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; irq = '0; stb = 1'b0; wre = 1'b0; adr = '0; wdat = '0;
        cyc(2);
        chk("rst_int", {31'd0, sint}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        rst = 1'b0;
        wb_rd(2'd2, d); chk("rst_ivr", d, 32'h8000_0000);

        // Edge source 0, 3-cycle pulse, latched.
        wb_wr(2'd3, 32'h01);
        wb_wr(2'd1, 32'h01);
        irq[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin chk("e0_int_k2", {31'd0, sint}, 32'd0); irq[0] = 1'b0; end
            if (c == 4) chk("e0_int_k3", {31'd0, sint}, 32'd1);
        end
        cyc(3);
        chk("e0_int_held", {31'd0, sint}, 32'd1);
        wb_rd(2'd0, d); chk("e0_isr", d, 32'h01);
        wb_wr(2'd0, 32'h01);
        chk("e0_clr_k", {31'd0, int_at_commit}, 32'd1);
        chk("e0_clr_k1", {31'd0, sint}, 32'd0);

        // Level source 2.
        wb_wr(2'd3, 32'h00);
        wb_wr(2'd1, 32'h04);
        irq[2] = 1'b1;
        cyc(5);
        wb_rd(2'd0, d); chk("l2_isr", d, 32'h04);
        wb_rd(2'd2, d); chk("l2_ivr", d, 32'h02);
        wb_wr(2'd0, 32'h04);
        wb_rd(2'd0, d); chk("l2_isr_noclr", d, 32'h04);
        irq[2] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) chk("l2_fall_k2", {31'd0, sint}, 32'd1);
            if (c == 4) chk("l2_fall_k3", {31'd0, sint}, 32'd0);
        end

        // Two edge sources, priority vector.
        wb_wr(2'd1, 32'hFF);
        wb_wr(2'd3, 32'hFF);
        irq = 8'h28;
        cyc(3);
        irq = 8'h00;
        cyc(3);
        wb_rd(2'd0, d); chk("e35_isr", d, 32'h28);
        wb_rd(2'd2, d); chk("e35_ivr", d, 32'h03);
        wb_wr(2'd0, 32'h08);
        wb_rd(2'd2, d); chk("e5_ivr", d, 32'h05);
        wb_wr(2'd0, 32'h20);
        wb_rd(2'd2, d); chk("none_ivr", d, 32'h8000_0000);
        chk("none_int", {31'd0, sint}, 32'd0);

        // Edge set and write-1-clear on the same edge: set wins.
        irq[1] = 1'b1;
        cyc(2);
        wb_wr(2'd0, 32'h02);
        wb_rd(2'd0, d); chk("setwin_isr", d, 32'h02);
        irq[1] = 1'b0;
        wb_wr(2'd0, 32'h02);
        wb_rd(2'd0, d); chk("setwin_clr", d, 32'h00);

        // Level->edge switch drops a held level bit.
        wb_wr(2'd3, 32'h00);
        irq[4] = 1'b1;
        cyc(5);
        wb_rd(2'd0, d); chk("sw_lvl_isr", d, 32'h10);
        wb_wr(2'd3, 32'h10);
        wb_rd(2'd0, d); chk("sw_edge_isr", d, 32'h00);
        irq[4] = 1'b0;

        // Held strobe commits once; bits above IRQ ignored.
        stb = 1'b1; wre = 1'b1; adr = 2'd1; wdat = 32'h0F;
        @(negedge clk);
        wdat = 32'hF0;
        cyc(3);
        chk("hold_ack", {31'd0, ack}, 32'd1);
        stb = 1'b0; wre = 1'b0;
        @(negedge clk);
        wb_rd(2'd1, d); chk("hold_ier", d, 32'h0F);
        wb_wr(2'd1, 32'hFFFF_FFFF);
        wb_rd(2'd1, d); chk("ier_width", d, 32'hFF);
        wb_wr(2'd2, 32'h0000_0001);
        wb_rd(2'd2, d); chk("ivr_ro", d, 32'h8000_0000);

        // Reset mid-access.
        wb_wr(2'd3, 32'hFF);
        irq[6] = 1'b1;
        cyc(3);
        irq[6] = 1'b0;
        cyc(3);
        chk("pre_rst_int", {31'd0, sint}, 32'd1);
        wb_rd(2'd0, d); chk("pre_rst_isr", d, 32'h40);
        stb = 1'b1; wre = 1'b1; adr = 2'd1; wdat = 32'h55;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_int", {31'd0, sint}, 32'd0);
        chk("mid_rst_dat", rdat, 32'd0);
        rst = 1'b0; stb = 1'b0; wre = 1'b0;
        @(negedge clk);
        wb_rd(2'd1, d); chk("post_rst_ier", d, 32'h00);
        wb_rd(2'd3, d); chk("post_rst_itr", d, 32'h00);
        wb_rd(2'd0, d); chk("post_rst_isr", d, 32'h00);
        wb_rd(2'd2, d); chk("post_rst_ivr", d, 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
